// File: rtl/rata_pkg.sv
// -----------------------------------------------------------------------------
// rata_pkg
//   Shared definitions for the RATA_B LMT sequencer: default data/address
//   widths, the LMT word address, the read timeout and the FSM state encoding.
// -----------------------------------------------------------------------------
package rata_pkg;

    localparam int         RATA_TW       = 32;
    localparam int         RATA_AW       = 8;
    localparam logic [7:0] RATA_LMT_ADDR = 8'h00;
    localparam int         RATA_TIMEOUT  = 15;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_RWAIT = 3'd3,
        ST_RESP  = 3'd4,
        ST_HALT  = 3'd5
    } rata_seq_state_t;

endpackage

// File: rtl/rata_ts_counter.sv
// -----------------------------------------------------------------------------
// rata_ts_counter
//   Free-running TW-bit timestamp. Increments every cycle and wraps from
//   2^TW-1 to 0. Only rst_n clears it.
// Ports
//   clk    in  1   clock
//   rst_n  in  1   asynchronous active-low reset
//   ts     out TW  current timestamp
// -----------------------------------------------------------------------------
module rata_ts_counter #(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [TW-1:0] ts
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TW'(1);
    end

endmodule

// File: rtl/rata_lmt_sequencer.sv
// -----------------------------------------------------------------------------
// rata_lmt_sequencer
//   Serialises every access to the LMT word for the RATA_B monitor. A rising
//   edge on up_lmt stamps the current timestamp into LMT memory; a verifier
//   attestation request reads LMT back and returns it with att_ack. While
//   rata_reset is high all memory traffic stops and in-flight work is dropped.
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   up_lmt                 LMT update request (rising edge)
//   rata_reset             monitor reset level, aborts and holds the sequencer
//   att_req/att_ack        verifier request level / one-cycle response strobe
//   att_lmt/att_err/att_stale  response data and qualifiers
//   mem_req/we/addr/wdata  single-port memory request, held until mem_gnt
//   mem_gnt/rvalid/rdata   memory grant and read return
//   ts                     free-running timestamp
//   busy                   sequencer not idle
// -----------------------------------------------------------------------------
module rata_lmt_sequencer
    import rata_pkg::*;
#(
    parameter int          TW       = RATA_TW,
    parameter int          AW       = RATA_AW,
    parameter logic [AW-1:0] LMT_ADDR = AW'(RATA_LMT_ADDR),
    parameter int          TIMEOUT  = RATA_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_lmt,
    input  logic          rata_reset,
    input  logic          att_req,
    output logic          att_ack,
    output logic [TW-1:0] att_lmt,
    output logic          att_err,
    output logic          att_stale,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [TW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [TW-1:0] mem_rdata,
    output logic [TW-1:0] ts,
    output logic          busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    rata_seq_state_t state, state_nxt;
    logic            up_lmt_q;
    logic            upd_pend;
    logic [TW-1:0]   stamp;
    logic [CW-1:0]   tcnt;
    logic            lmt_edge;
    logic            rd_timeout;

    rata_ts_counter #(.TW(TW)) u_ts (
        .clk   (clk),
        .rst_n (rst_n),
        .ts    (ts)
    );

    assign lmt_edge   = up_lmt & ~up_lmt_q;
    assign rd_timeout = (tcnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            // An edge seen this cycle becomes upd_pend next cycle; holding off
            // the read for that one cycle keeps a simultaneous update ahead.
            ST_IDLE:  if (upd_pend)                    state_nxt = ST_WR;
                      else if (att_req && !lmt_edge)   state_nxt = ST_RD;
            ST_WR:    if (mem_gnt)                     state_nxt = ST_IDLE;
            ST_RD:    if (mem_gnt)                     state_nxt = ST_RWAIT;
            ST_RWAIT: if (mem_rvalid || rd_timeout)    state_nxt = ST_RESP;
            ST_RESP:                                   state_nxt = ST_IDLE;
            ST_HALT:  if (!rata_reset)                 state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
        if (rata_reset) state_nxt = ST_HALT;
    end

    assign mem_req   = (state == ST_WR) || (state == ST_RD);
    assign mem_we    = (state == ST_WR);
    assign mem_addr  = mem_req ? LMT_ADDR : '0;
    assign mem_wdata = (state == ST_WR) ? stamp : '0;
    assign att_ack   = (state == ST_RESP);
    assign att_stale = (state == ST_RESP) && upd_pend;
    assign busy      = (state != ST_IDLE);

    // Edge history keeps tracking during HALT so a level held across the
    // halt is not mistaken for a fresh request on exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) up_lmt_q <= 1'b0;
        else        up_lmt_q <= up_lmt;
    end

    // Pending writes coalesce: the newest edge owns the stamp, and an edge in
    // the grant cycle keeps the request alive for another write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upd_pend <= 1'b0;
            stamp    <= '0;
        end else if (state == ST_HALT) begin
            upd_pend <= 1'b0;
        end else if (lmt_edge) begin
            upd_pend <= 1'b1;
            stamp    <= ts;
        end else if (state == ST_WR && mem_gnt) begin
            upd_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              tcnt <= '0;
        else if (state == ST_RD && mem_gnt)      tcnt <= '0;
        else if (state == ST_RWAIT && !mem_rvalid && !rd_timeout)
                                                 tcnt <= tcnt + CW'(1);
    end

    // A read aborted by rata_reset never updates the response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            att_lmt <= '0;
            att_err <= 1'b0;
        end else if (state == ST_RWAIT && !rata_reset) begin
            if (mem_rvalid) begin
                att_lmt <= mem_rdata;
                att_err <= 1'b0;
            end else if (rd_timeout) begin
                att_lmt <= '0;
                att_err <= 1'b1;
            end
        end
    end

endmodule
